rll_key_sequencer: RTL and testbench

Sequential wrapper that owns the key inputs of an RLL-locked combinational benchmark core with 16 key bits, 32 primary inputs and 32 primary outputs. It loads the key in fixed-width chunks over a valid/ready channel, holds it stable, and gates the core. It then streams test vectors through the core with a registered input stage and a registered result stage. It sits between the test harness / key source and the locked netlist.

---
 rtl/rll_key_sequencer_pkg.sv | 21 ++
 rtl/rll_key_sequencer_if.sv | 30 +++
 rtl/rll_pipe_stage.sv | 38 +++
 rtl/rll_key_sequencer.sv | 130 +++++++++++++
 tb/tb_rll_key_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rll_key_sequencer_pkg.sv
// Shared definitions for the RLL key sequencer: sequencer state encoding,
// default widths and the chunk-count helper used to size the load counter.
package rll_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ACTIVE = 2'd2,
      DRAIN  = 2'd3
   } seq_state_t;

   localparam int KEY_W_DEF   = 16;
   localparam int CHUNK_W_DEF = 4;
   localparam int DATA_W_DEF  = 32;

   // Number of chunk transfers needed to fill the key shadow.
   function automatic int chunk_count(input int key_w, input int chunk_w);
      return key_w / chunk_w;
   endfunction

endpackage

// File: rtl/rll_key_sequencer_if.sv
// Harness-side channels of the RLL key sequencer: load control, key chunk
// channel, test-vector channel and result channel.
//   master : test harness / key source
//   slave  : rll_key_sequencer
interface rll_key_sequencer_if #(
   parameter int CHUNK_W = 4,
   parameter int DATA_W  = 32
);
   logic               load_start;
   logic               key_valid;
   logic               key_ready;
   logic [CHUNK_W-1:0] key_chunk;
   logic               key_loaded;
   logic               vec_valid;
   logic               vec_ready;
   logic [DATA_W-1:0]  vec_data;
   logic               res_valid;
   logic               res_ready;
   logic [DATA_W-1:0]  res_data;

   modport master (
      output load_start, key_valid, key_chunk, vec_valid, vec_data, res_ready,
      input  key_ready, key_loaded, vec_ready, res_valid, res_data
   );

   modport slave (
      input  load_start, key_valid, key_chunk, vec_valid, vec_data, res_ready,
      output key_ready, key_loaded, vec_ready, res_valid, res_data
   );
endinterface

// File: rtl/rll_pipe_stage.sv
// Single valid/ready register slice. Accepts a new word whenever it is empty
// or its current word leaves in the same cycle, so a chain of these runs at
// one word per cycle. Data holds its last value when the slice is empty.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_data upstream word
//   out_valid/out_ready downstream handshake, out_data registered word
module rll_pipe_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         v_q;
   logic [W-1:0] data_q;

   assign in_ready  = !v_q || out_ready;
   assign out_valid = v_q;
   assign out_data  = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= 1'b0;
         data_q <= '0;
      end else if (in_valid && in_ready) begin
         v_q    <= 1'b1;
         data_q <= in_data;
      end else if (out_ready) begin
         v_q    <= 1'b0;
      end
   end
endmodule

// File: rtl/rll_key_sequencer.sv
// Sequential wrapper around an RLL-locked combinational core. Loads the key
// in CHUNK_W-bit pieces into a shadow register, drives it to the core only
// once complete, then streams vectors through a two-stage pipeline
// (S1 = core_in register, S2 = result register).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        harness channels (load/key/vector/result), slave side
//   core_key   key to the core keyIn ports, zero unless a full key is loaded
//   core_in    registered primary inputs to the core
//   core_out   primary outputs from the core
//
// state  | meaning
// IDLE   | no key; channels closed
// LOAD   | accepting key chunks into the shadow
// ACTIVE | key driven to core; vectors accepted
// DRAIN  | new load requested; flushing in-flight vectors with the old key
module rll_key_sequencer
   import rll_seq_pkg::*;
#(
   parameter int KEY_W   = KEY_W_DEF,
   parameter int CHUNK_W = CHUNK_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   rll_key_sequencer_if.slave bus,
   output logic [KEY_W-1:0]  core_key,
   output logic [DATA_W-1:0] core_in,
   input  logic [DATA_W-1:0] core_out
);
   localparam int N_CHUNK = chunk_count(KEY_W, CHUNK_W);
   localparam int CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [KEY_W-1:0] shadow_q;
   logic             key_clr, key_wr, key_ready, key_loaded, vec_en;
   logic             last_chunk;
   logic             s1_v, s2_v, s1_in_ready, s2_in_ready;

   assign last_chunk = (cnt_q == CNT_W'(N_CHUNK - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      key_clr    = 1'b0;
      key_wr     = 1'b0;
      key_ready  = 1'b0;
      key_loaded = 1'b0;
      vec_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.load_start) begin
               key_clr = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            key_ready = 1'b1;
            // A restart wins over a chunk presented in the same cycle.
            if (bus.load_start) begin
               key_clr = 1'b1;
            end else if (bus.key_valid) begin
               key_wr = 1'b1;
               if (last_chunk) state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            key_loaded = 1'b1;
            vec_en     = 1'b1;
            if (bus.load_start) state_d = DRAIN;
         end
         DRAIN: begin
            key_loaded = 1'b1;
            if (!s1_v && !s2_v) begin
               key_clr = 1'b1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         shadow_q <= '0;
      end else if (key_clr) begin
         cnt_q    <= '0;
         shadow_q <= '0;
      end else if (key_wr) begin
         cnt_q <= cnt_q + CNT_W'(1);
         for (int i = 0; i < N_CHUNK; i++) begin
            if (cnt_q == CNT_W'(i)) shadow_q[i*CHUNK_W +: CHUNK_W] <= bus.key_chunk;
         end
      end
   end

   assign core_key       = key_loaded ? shadow_q : '0;
   assign bus.key_ready  = key_ready;
   assign bus.key_loaded = key_loaded;
   assign bus.vec_ready  = vec_en && s1_in_ready;
   assign bus.res_valid  = s2_v;

   rll_pipe_stage #(.W(DATA_W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.vec_valid && vec_en),
      .in_ready  (s1_in_ready),
      .in_data   (bus.vec_data),
      .out_valid (s1_v),
      .out_ready (s2_in_ready),
      .out_data  (core_in)
   );

   rll_pipe_stage #(.W(DATA_W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_v),
      .in_ready  (s2_in_ready),
      .in_data   (core_out),
      .out_valid (s2_v),
      .out_ready (bus.res_ready),
      .out_data  (bus.res_data)
   );
endmodule

// File: tb/tb_rll_key_sequencer.sv
// Self-checking bench for rll_key_sequencer. A behavioural locked-core model
// drives core_out; a scoreboard queue holds the expected result of every
// accepted vector, computed from the key the harness believes is active.
module tb_rll_key_sequencer;
   localparam int KEY_W   = 16;
   localparam int CHUNK_W = 4;
   localparam int DATA_W  = 32;
   localparam int N_CHUNK = KEY_W / CHUNK_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [KEY_W-1:0]  core_key;
   logic [DATA_W-1:0] core_in;
   logic [DATA_W-1:0] core_out;

   int                n_assert = 0;
   int                n_fail   = 0;
   int                n_res    = 0;
   logic [KEY_W-1:0]  model_key = '0;
   logic [DATA_W-1:0] sb_q[$];

   rll_key_sequencer_if #(.CHUNK_W(CHUNK_W), .DATA_W(DATA_W)) bus ();

   rll_key_sequencer #(.KEY_W(KEY_W), .CHUNK_W(CHUNK_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .core_key (core_key),
      .core_in  (core_in),
      .core_out (core_out)
   );

   always #5 clk = ~clk;

   // Stand-in for the locked netlist: output depends on every key bit.
   function automatic logic [DATA_W-1:0] core_fn(input logic [DATA_W-1:0] d,
                                                 input logic [KEY_W-1:0] k);
      return ({d[15:0], d[31:16]} ^ {k, ~k}) + 32'h1357_9BDF;
   endfunction

   assign core_out = core_fn(core_in, core_key);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.res_valid && bus.res_ready) begin
            n_res++;
            if (sb_q.size() == 0) chk("res_extra", bus.res_data, ~bus.res_data);
            else                  chk("res_data", bus.res_data, sb_q.pop_front());
         end
         if (bus.vec_valid && bus.vec_ready)
            sb_q.push_back(core_fn(bus.vec_data, model_key));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_load();
      int b;
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
      b = 0;
      while (!bus.key_ready && b < 10) begin
         tick();
         b++;
      end
      chk("load_enter", bus.key_ready, 1);
      chk("load_key0", core_key, 0);
      chk("load_kl0", bus.key_loaded, 0);
   endtask

   task automatic send_chunks(input logic [KEY_W-1:0] k, input int n);
      for (int i = 0; i < n; i++) begin
         bus.key_valid = 1'b1;
         bus.key_chunk = k[i*CHUNK_W +: CHUNK_W];
         chk("chunk_ready", bus.key_ready, 1);
         tick();
         if (i == N_CHUNK - 1) begin
            chk("key_loaded", bus.key_loaded, 1);
            chk("core_key", core_key, k);
         end else begin
            chk("partial_kl", bus.key_loaded, 0);
            chk("partial_key", core_key, 0);
         end
      end
      bus.key_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int b = 0;
      while ((sb_q.size() != 0 || bus.res_valid) && b < 20) begin
         tick();
         b++;
      end
      chk("drain_q", sb_q.size(), 0);
      chk("drain_rv", bus.res_valid, 0);
   endtask

   task automatic send_stream(input int n);
      int r0 = n_res;
      bus.res_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.vec_valid = 1'b1;
         bus.vec_data  = $urandom;
         chk("stream_ready", bus.vec_ready, 1);
         tick();
         chk("stream_rv", bus.res_valid, (i >= 1) ? 1 : 0);
      end
      bus.vec_valid = 1'b0;
      wait_empty();
      chk("stream_count", n_res - r0, n);
   endtask

   initial begin
      logic [KEY_W-1:0]  k2, k3, ka, kb;
      logic [DATA_W-1:0] bp_vec[3];
      int idx, prev, r0, b;

      rst            = 1'b1;
      bus.load_start = 1'b0;
      bus.key_valid  = 1'b0;
      bus.key_chunk  = '0;
      bus.vec_valid  = 1'b0;
      bus.vec_data   = '0;
      bus.res_ready  = 1'b0;
      tick();
      tick();
      chk("rst_key_ready", bus.key_ready, 0);
      chk("rst_key_loaded", bus.key_loaded, 0);
      chk("rst_vec_ready", bus.vec_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_core_in", core_in, 0);
      rst = 1'b0;
      tick();

      // Directed key 0xC5A3 (chunks 3,A,5,C)
      begin_load();
      send_chunks(16'hC5A3, N_CHUNK);
      model_key = 16'hC5A3;

      // key_valid outside LOAD is ignored
      bus.key_valid = 1'b1;
      bus.key_chunk = 4'hF;
      tick();
      bus.key_valid = 1'b0;
      chk("key_ignored", core_key, 16'hC5A3);

      send_stream(8);

      // Backpressure: 3 vectors offered with res_ready low for 5 cycles
      for (int i = 0; i < 3; i++) bp_vec[i] = $urandom;
      bus.res_ready = 1'b0;
      idx = 0;
      r0  = n_res;
      for (int c = 0; c < 5; c++) begin
         bus.vec_valid = (idx < 3);
         bus.vec_data  = bp_vec[idx % 3];
         chk("bp_ready", bus.vec_ready, (sb_q.size() < 2) ? 1 : 0);
         chk("bp_rv", bus.res_valid, (c >= 2) ? 1 : 0);
         if (bus.res_valid && sb_q.size() != 0) chk("bp_hold", bus.res_data, sb_q[0]);
         prev = sb_q.size();
         tick();
         if (sb_q.size() > prev) idx++;
      end
      chk("bp_accepted", idx, 2);
      bus.res_ready = 1'b1;
      b = 0;
      while (idx < 3 && b < 10) begin
         bus.vec_valid = 1'b1;
         bus.vec_data  = bp_vec[2];
         prev = n_res + sb_q.size();
         tick();
         if (n_res + sb_q.size() > prev) idx++;
         b++;
      end
      bus.vec_valid = 1'b0;
      chk("bp_third", idx, 3);
      wait_empty();
      chk("bp_count", n_res - r0, 3);

      // load_start with 2 vectors in flight
      bus.res_ready = 1'b0;
      r0 = n_res;
      for (int i = 0; i < 2; i++) begin
         bus.vec_valid = 1'b1;
         bus.vec_data  = $urandom;
         tick();
      end
      bus.vec_valid = 1'b0;
      chk("inflight", sb_q.size(), 2);
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
      bus.vec_valid  = 1'b1;
      bus.vec_data   = $urandom;
      chk("drain_vready", bus.vec_ready, 0);
      chk("drain_kl", bus.key_loaded, 1);
      chk("drain_key", core_key, 16'hC5A3);
      bus.res_ready = 1'b1;
      b = 0;
      while (!bus.key_ready && b < 10) begin
         tick();
         b++;
      end
      bus.vec_valid = 1'b0;
      chk("drain_to_load", bus.key_ready, 1);
      chk("drain_results", n_res - r0, 2);
      chk("drain_q_empty", sb_q.size(), 0);
      chk("drain_load_key", core_key, 0);
      send_chunks(16'h0001, N_CHUNK);
      model_key = 16'h0001;
      send_stream(3);

      // Reset mid-load after 2 chunks
      k2 = 16'($urandom);
      begin_load();
      send_chunks(k2, 2);
      rst = 1'b1;
      tick();
      chk("mrst_key_ready", bus.key_ready, 0);
      chk("mrst_key_loaded", bus.key_loaded, 0);
      chk("mrst_vec_ready", bus.vec_ready, 0);
      chk("mrst_res_valid", bus.res_valid, 0);
      chk("mrst_res_data", bus.res_data, 0);
      chk("mrst_core_key", core_key, 0);
      chk("mrst_core_in", core_in, 0);
      rst = 1'b0;
      sb_q.delete();
      tick();
      k3 = 16'($urandom);
      begin_load();
      send_chunks(k3, N_CHUNK);
      model_key = k3;
      send_stream(4);

      // load_start repeated after 3 chunks restarts the count
      ka = 16'($urandom);
      kb = 16'($urandom) ^ 16'h8421;
      begin_load();
      send_chunks(ka, 3);
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
      chk("restart_kl", bus.key_loaded, 0);
      send_chunks(kb, N_CHUNK);
      model_key = kb;
      send_stream(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
